apple_iie_timing_gen: RTL and testbench

//  Parametrised successor to the fixed Apple IIe timing PAL. Derives all CPU/video/DRAM

---
 rtl/apple_iie_timing_gen.sv | 106 ++++++++++
 tb/tb_apple_iie_timing_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_iie_timing_gen.sv
// apple_iie_timing_gen: CPU/video/DRAM timing generator driven from the 14.318 MHz master clock.
// Produces 7M, Q3, PHI0/PHI1, RAS_n/CAS_n and AX, and stretches the last CPU cycle of each
// horizontal line. Also provides PHI0 edge strobes and a per-line CPU cycle counter.
//
// Ports:
//   clk_14M      in   master clock, sole clock of the block
//   reset        in   asynchronous active-high reset
//   stretch_en   in   1 = last cycle of each line is long; sampled only when a cycle starts
//   clk_7M       out  clk_14M / 2
//   clk_q3       out  asymmetric Q3 strobe clock
//   clk_phi_0    out  CPU phase 0
//   clk_phi_1    out  inverse of clk_phi_0
//   ras_n        out  DRAM row strobe, active low
//   cas_n        out  DRAM column strobe, active low
//   ax           out  1 = row address on DRAM mux
//   phi0_rise    out  one-tick strobe on the first tick with clk_phi_0 high
//   phi0_fall    out  one-tick strobe on the first tick of a new cycle
//   long_cycle   out  high for every tick of a stretched cycle
//   cycle_count  out  CPU cycle index within the line
module apple_iie_timing_gen #(
    parameter int unsigned HALF_CYCLE    = 7,
    parameter int unsigned LINE_CYCLES   = 65,
    parameter int unsigned STRETCH_TICKS = 2,
    parameter int unsigned Q3_HIGH       = 4,
    localparam int unsigned CW           = $clog2(LINE_CYCLES)
) (
    input  logic          clk_14M,
    input  logic          reset,
    input  logic          stretch_en,
    output logic          clk_7M,
    output logic          clk_q3,
    output logic          clk_phi_0,
    output logic          clk_phi_1,
    output logic          ras_n,
    output logic          cas_n,
    output logic          ax,
    output logic          phi0_rise,
    output logic          phi0_fall,
    output logic          long_cycle,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned TW = $clog2(2 * HALF_CYCLE + STRETCH_TICKS);

    localparam logic [TW-1:0] H_T       = TW'(HALF_CYCLE);
    localparam logic [TW-1:0] END_SHORT = TW'(2 * HALF_CYCLE - 1);
    localparam logic [TW-1:0] END_LONG  = TW'(2 * HALF_CYCLE - 1 + STRETCH_TICKS);
    localparam logic [TW-1:0] Q3_T      = TW'(Q3_HIGH);
    localparam logic [CW-1:0] LAST_CYC  = CW'(LINE_CYCLES - 1);
    localparam logic          HAS_STRETCH = (STRETCH_TICKS != 0);

    logic [TW-1:0] t;
    logic [TW-1:0] t_nx;
    logic [TW-1:0] p_nx;
    logic [CW-1:0] cc_nx;
    logic          long_nx;
    logic          phi0_nx;

    // Next tick / cycle / long flag; outputs are decoded from these so they track t with no lag.
    always_comb begin
        t_nx    = t + TW'(1);
        cc_nx   = cycle_count;
        long_nx = long_cycle;
        if (t == (long_cycle ? END_LONG : END_SHORT)) begin
            t_nx    = '0;
            cc_nx   = (cycle_count == LAST_CYC) ? '0 : cycle_count + CW'(1);
            long_nx = stretch_en && (cc_nx == LAST_CYC) && HAS_STRETCH;
        end
        phi0_nx = (t_nx >= H_T);
        // Stretch ticks give p >= HALF_CYCLE, so Q3/AX/RAS_n/CAS_n stay low there.
        p_nx    = phi0_nx ? t_nx - H_T : t_nx;
    end

    // State and registered outputs.
    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            t           <= '0;
            cycle_count <= '0;
            long_cycle  <= 1'b0;
            clk_7M      <= 1'b0;
            clk_phi_0   <= 1'b0;
            clk_phi_1   <= 1'b1;
            clk_q3      <= 1'b1;
            ax          <= 1'b1;
            ras_n       <= 1'b1;
            cas_n       <= 1'b1;
            phi0_rise   <= 1'b0;
            phi0_fall   <= 1'b0;
        end else begin
            t           <= t_nx;
            cycle_count <= cc_nx;
            long_cycle  <= long_nx;
            clk_7M      <= ~clk_7M;
            clk_phi_0   <= phi0_nx;
            clk_phi_1   <= ~phi0_nx;
            clk_q3      <= (p_nx < Q3_T);
            ax          <= (p_nx < TW'(3));
            ras_n       <= (p_nx < TW'(2));
            cas_n       <= (p_nx < TW'(4));
            phi0_rise   <= (t_nx == H_T);
            // t only returns to 0 from the end tick, so the reset cycle never strobes.
            phi0_fall   <= (t_nx == '0);
        end
    end

endmodule

// File: tb/tb_apple_iie_timing_gen.sv
module tb_apple_iie_timing_gen;

    logic clk_14M = 1'b0;
    logic reset = 1'b1;
    logic stretch_en = 1'b1;
    logic stretch_en2 = 1'b1;

    logic a_7m, a_q3, a_phi0, a_phi1, a_ras, a_cas, a_ax, a_rise, a_fall, a_long;
    logic [6:0] a_cc;
    logic b_7m, b_q3, b_phi0, b_phi1, b_ras, b_cas, b_ax, b_rise, b_fall, b_long;
    logic [1:0] b_cc;

    int passed = 0;
    int total = 0;

    always #5 clk_14M = ~clk_14M;

    apple_iie_timing_gen dut (
        .clk_14M(clk_14M), .reset(reset), .stretch_en(stretch_en),
        .clk_7M(a_7m), .clk_q3(a_q3), .clk_phi_0(a_phi0), .clk_phi_1(a_phi1),
        .ras_n(a_ras), .cas_n(a_cas), .ax(a_ax), .phi0_rise(a_rise),
        .phi0_fall(a_fall), .long_cycle(a_long), .cycle_count(a_cc)
    );

    apple_iie_timing_gen #(
        .HALF_CYCLE(8), .LINE_CYCLES(4), .STRETCH_TICKS(3), .Q3_HIGH(4)
    ) dut2 (
        .clk_14M(clk_14M), .reset(reset), .stretch_en(stretch_en2),
        .clk_7M(b_7m), .clk_q3(b_q3), .clk_phi_0(b_phi0), .clk_phi_1(b_phi1),
        .ras_n(b_ras), .cas_n(b_cas), .ax(b_ax), .phi0_rise(b_rise),
        .phi0_fall(b_fall), .long_cycle(b_long), .cycle_count(b_cc)
    );

    // Packed observation: [31:22] = {7M,q3,phi0,phi1,ras_n,cas_n,ax,rise,fall,long}, [21:0] = cycle.
    logic [31:0] dv [2];
    always_comb begin
        dv[0] = {a_7m, a_q3, a_phi0, a_phi1, a_ras, a_cas, a_ax, a_rise, a_fall, a_long, 22'(a_cc)};
        dv[1] = {b_7m, b_q3, b_phi0, b_phi1, b_ras, b_cas, b_ax, b_rise, b_fall, b_long, 22'(b_cc)};
    end

    localparam logic [31:0] RST_V = {10'b0101111000, 22'd0};
    localparam logic [31:0] T1_V  = {10'b1101111000, 22'd0};

    // Reference model: tick k within a cycle of length len, chosen when the cycle starts.
    typedef struct packed {
        int k;
        int len;
        int c;
        bit ph7;
        bit fresh;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t mreset(int h);
        mstate_t r;
        r.k = 0; r.len = 2 * h; r.c = 0; r.ph7 = 1'b0; r.fresh = 1'b1;
        return r;
    endfunction

    function automatic mstate_t mnext(mstate_t s, int h, int lc, int st, bit se);
        mstate_t r;
        r = s;
        r.fresh = 1'b0;
        r.ph7 = ~s.ph7;
        if (s.k == s.len - 1) begin
            r.k = 0;
            r.c = (s.c == lc - 1) ? 0 : s.c + 1;
            r.len = 2 * h + ((se && r.c == lc - 1) ? st : 0);
        end else begin
            r.k = s.k + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] mvec(mstate_t s, int h, int q3h);
        int p;
        bit phi0;
        phi0 = (s.k >= h);
        p = phi0 ? s.k - h : s.k;
        return {s.ph7, (p < q3h), phi0, !phi0, (p < 2), (p < 4), (p < 3),
                (s.k == h), (s.k == 0 && !s.fresh), (s.len > 2 * h), 22'(s.c)};
    endfunction

    function automatic logic [31:0] expv(int idx);
        return (idx == 0) ? mvec(m0, 7, 4) : mvec(m1, 8, 4);
    endfunction

    always @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            m0 <= mreset(7);
            m1 <= mreset(8);
        end else begin
            m0 <= mnext(m0, 7, 65, 2, stretch_en);
            m1 <= mnext(m1, 8, 4, 3, stretch_en2);
        end
    end

    // Advance to the first tick of a line (cycle 0, fall strobe) on the chosen instance.
    task automatic sync_line(input int idx);
        int n;
        n = 0;
        while (!(dv[idx][23] && dv[idx][21:0] == 22'd0) && n < 3000) begin
            @(negedge clk_14M);
            n++;
        end
        if (n >= 3000) begin
            total++;
            $display("FAIL sync_line%0d: no line start within %0d ticks", idx, n);
        end
    endtask

    // Step tick by tick against the model until the next line start (or max_ticks).
    task automatic measure_line(input int idx, input int max_ticks, input int toggle_at,
                                output int len, output int long_ticks, output int hi_long);
        len = 0; long_ticks = 0; hi_long = 0;
        do begin
            @(negedge clk_14M);
            len++;
            if (len == toggle_at) stretch_en = ~stretch_en;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dv[i] !== expv(i))
                    $display("FAIL model_dut%0d tick %0d: got %h expected %h", i, len, dv[i], expv(i));
                else passed++;
            end
            if (dv[idx][22]) begin
                long_ticks++;
                if (dv[idx][29]) hi_long++;
            end
        end while (!(dv[idx][23] && dv[idx][21:0] == 22'd0) && len < max_ticks);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_14M);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (dv[i] !== RST_V) $display("FAIL reset_held dut%0d: got %h expected %h", i, dv[i], RST_V);
            else passed++;
        end
        reset = 1'b0;
        @(negedge clk_14M);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (dv[i] !== T1_V) $display("FAIL first_tick dut%0d: got %h expected %h", i, dv[i], T1_V);
            else passed++;
        end
    endtask

    task automatic test_stretch_line();
        int len, lt, hl;
        stretch_en = 1'b1;
        sync_line(0);
        measure_line(0, 3000, -1, len, lt, hl);
        total++;
        if (len !== 912) $display("FAIL stretch_line_len: got %0d expected 912", len); else passed++;
        total++;
        if (lt !== 16) $display("FAIL stretch_long_ticks: got %0d expected 16", lt); else passed++;
        total++;
        if (hl !== 9) $display("FAIL stretch_phi0_high: got %0d expected 9", hl); else passed++;
    endtask

    task automatic test_no_stretch();
        int len, lt, hl;
        stretch_en = 1'b0;
        sync_line(0);
        measure_line(0, 3000, -1, len, lt, hl);
        total++;
        if (len !== 910) $display("FAIL nostretch_line_len: got %0d expected 910", len); else passed++;
        total++;
        if (lt !== 0) $display("FAIL nostretch_long_ticks: got %0d expected 0", lt); else passed++;
    endtask

    task automatic test_toggle_mid_long();
        int len, lt, hl;
        stretch_en = 1'b1;
        sync_line(0);
        // Tick 906 of the line is tick 10 of cycle 64.
        measure_line(0, 3000, 906, len, lt, hl);
        total++;
        if (len !== 912) $display("FAIL toggle_line_len: got %0d expected 912", len); else passed++;
        total++;
        if (lt !== 16) $display("FAIL toggle_long_ticks: got %0d expected 16", lt); else passed++;
        measure_line(0, 3000, -1, len, lt, hl);
        total++;
        if (len !== 910) $display("FAIL toggle_next_len: got %0d expected 910", len); else passed++;
    endtask

    task automatic test_decode();
        logic [6:0] exp_bits;
        bit q3, ax, ras, phi0;
        stretch_en = 1'b0;
        sync_line(0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk_14M);
            q3   = (k <= 3) || (k >= 7 && k <= 10);
            ax   = (k <= 2) || (k >= 7 && k <= 9);
            ras  = (k <= 1) || k == 7 || k == 8;
            phi0 = (k >= 7);
            exp_bits = {q3, phi0, !phi0, ras, q3, ax, (k == 7)};
            total++;
            if (dv[0][30:24] !== exp_bits)
                $display("FAIL decode t=%0d: got %b expected %b", k, dv[0][30:24], exp_bits);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_long();
        int len, lt, hl, n;
        stretch_en = 1'b1;
        sync_line(0);
        measure_line(0, 911, -1, len, lt, hl);
        total++;
        if (dv[0][22] !== 1'b1 || dv[0][21:0] !== 22'd64)
            $display("FAIL pre_reset_pos: got long=%b cyc=%0d expected long=1 cyc=64", dv[0][22], dv[0][21:0]);
        else passed++;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (dv[i] !== RST_V) $display("FAIL async_reset dut%0d: got %h expected %h", i, dv[i], RST_V);
            else passed++;
        end
        @(negedge clk_14M);
        reset = 1'b0;
        @(negedge clk_14M);
        total++;
        if (dv[0] !== T1_V) $display("FAIL post_reset_tick: got %h expected %h", dv[0], T1_V); else passed++;
        n = 1;
        while (!dv[0][23] && n < 100) begin
            @(negedge clk_14M);
            n++;
        end
        total++;
        if (n !== 14 || dv[0][21:0] !== 22'd1)
            $display("FAIL post_reset_cycle: got len=%0d cyc=%0d expected len=14 cyc=1", n, dv[0][21:0]);
        else passed++;
    endtask

    task automatic test_params();
        int len, lt, hl;
        stretch_en2 = 1'b1;
        sync_line(1);
        measure_line(1, 3000, -1, len, lt, hl);
        total++;
        if (len !== 67) $display("FAIL params_line_len: got %0d expected 67", len); else passed++;
        total++;
        if (lt !== 19) $display("FAIL params_long_ticks: got %0d expected 19", lt); else passed++;
        total++;
        if (hl !== 11) $display("FAIL params_phi0_high: got %0d expected 11", hl); else passed++;
    endtask

    task automatic test_random();
        int rst_at;
        rst_at = 1000 + int'($urandom_range(0, 1500));
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_14M);
            if (n == rst_at) begin
                #($urandom_range(1, 4)) reset = 1'b1;
                #1;
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (dv[i] !== RST_V) $display("FAIL rand_reset dut%0d: got %h expected %h", i, dv[i], RST_V);
                    else passed++;
                end
                @(negedge clk_14M);
                reset = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) stretch_en = ~stretch_en;
            if ($urandom_range(0, 29) == 0) stretch_en2 = ~stretch_en2;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dv[i] !== expv(i))
                    $display("FAIL rand_model dut%0d n=%0d: got %h expected %h", i, n, dv[i], expv(i));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stretch_line();
        test_no_stretch();
        test_toggle_mid_long();
        test_decode();
        test_reset_mid_long();
        test_params();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
